// File: rtl/midi_rx_fifo.sv
// -----------------------------------------------------------------------------
// midi_rx_fifo
//
// MIDI/UART serial receiver with a small output FIFO. The asynchronous Rx line
// is synchronised, framed by a five-state FSM (IDLE, START, DATA, STOP, BREAK)
// using mid-bit sampling, and good words are queued for a valid/ready consumer
// so that a status + data burst survives a busy parser.
//
// Build option:
//   MIDI_RX_MAJORITY_EN - when defined, every START/DATA/STOP sample is the
//                         2-of-3 majority of rx_s at the nominal cycle -1/0/+1.
//                         The decision is taken at +1, so all sample points and
//                         the FIFO write move one cycle later.
//
// Parameters:
//   CLKS_PER_BIT - Clk cycles per serial bit (>= 8)
//   DATA_BITS    - data bits per frame, 5..9, LSB first
//   FIFO_DEPTH   - output FIFO entries, power of two, >= 2
//
// Ports:
//   Clk        - system clock, all state changes on its rising edge
//   Rst_n      - synchronous active-low reset
//   Rx         - asynchronous serial input, idle high
//   rx_data    - FIFO head word, zero while the FIFO is empty
//   rx_valid   - FIFO non-empty
//   rx_ready   - consumer pops the head when rx_valid && rx_ready
//   frame_err  - one-cycle pulse, stop bit sampled low
//   overrun    - one-cycle pulse, good frame arrived while FIFO full
//   busy       - FSM is not IDLE
//   fifo_count - current FIFO occupancy
// -----------------------------------------------------------------------------
module midi_rx_fifo #(
  parameter int CLKS_PER_BIT = 1600,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          Rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
`ifdef MIDI_RX_MAJORITY_EN
  // Decision one cycle after the nominal mid-start point.
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2);
`else
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
`endif
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser (and majority history when enabled)
  // ---------------------------------------------------------------------------
  logic rx_m, rx_s;
  logic sample_bit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= Rx;
      rx_s <= rx_m;
    end
  end

`ifdef MIDI_RX_MAJORITY_EN
  logic rx_d1, rx_d2;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  // At the decision cycle rx_s is the +1 sample, rx_d1 nominal, rx_d2 -1.
  assign sample_bit = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  assign sample_bit = rx_s;
`endif

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   wr_pend_q, wr_pend_d;
  logic                   frame_err_q, frame_err_d;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_pend_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_pend_q   <= wr_pend_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    wr_pend_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == START_LAST) begin
          cnt_d   = '0;
          state_d = sample_bit ? IDLE : DATA;   // high here is a glitch
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sample_bit, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sample_bit) begin
            wr_pend_d = 1'b1;      // shift_q holds the word until the write
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;  // line must return high before re-arming
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 pop, full, push_ok;
  logic                 overrun_q;

  assign rx_valid = (fifo_count != '0);
  assign pop      = rx_valid && rx_ready;
  assign full     = (fifo_count == FULL_CNT);
  assign push_ok  = wr_pend_q && (!full || pop);   // a pop frees the slot first

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are live, and rx_data is forced to zero while empty.
  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= wr_pend_q && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign rx_data = rx_valid ? mem[rd_ptr] : '0;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_midi_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_midi_rx_fifo
//
// Directed bench for midi_rx_fifo with CLKS_PER_BIT=16, DATA_BITS=8,
// FIFO_DEPTH=4. Serial frames are driven bit by bit; a negedge monitor records
// popped words and flag pulses, and the main sequence compares them against
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_midi_rx_fifo;

  localparam int CPB = 16;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state
  logic [7:0] popped[$];
  int         fe_cnt    = 0;
  int         ov_cnt    = 0;
  int         valid_cyc = 0;

  midi_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .FIFO_DEPTH  (4)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Rx        (Rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 Clk = ~Clk;

  // Inputs change 1 time unit after posedge, so negedge sees stable values.
  always @(negedge Clk) begin
    if (rx_valid && rx_ready) popped.push_back(rx_data);
    if (rx_valid)  valid_cyc++;
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    Rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b1);
  endtask

  task automatic clear_mon();
    popped.delete();
    fe_cnt    = 0;
    ov_cnt    = 0;
    valid_cyc = 0;
  endtask

  initial begin
    Rst_n    = 1'b0;
    Rx       = 1'b1;
    rx_ready = 1'b0;
    tick(4);
    Rst_n = 1'b1;
    tick(2);

    // Reset state
    check("rst_valid", rx_valid,   1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_data",  rx_data,    8'h00);
    check("rst_ferr",  frame_err,  1'b0);
    check("rst_ovr",   overrun,    1'b0);
    check("rst_busy",  busy,       1'b0);
    tick(10);

    // Single frame 0x90, consumer ready
    clear_mon();
    rx_ready = 1'b1;
    send_frame(8'h90);
    check("t1_busy_end", busy, 1'b0);
    tick(10);
    check("t1_npop",  popped.size(), 1);
    check("t1_data",  popped[0],     8'h90);
    check("t1_vcyc",  valid_cyc,     1);
    check("t1_ferr",  fe_cnt,        0);
    check("t1_ovr",   ov_cnt,        0);
    check("t1_count", fifo_count,    3'd0);

    // Three back-to-back frames held, then drained
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h92);
    send_frame(8'h3C);
    send_frame(8'h64);
    tick(10);
    check("t2_count", fifo_count, 3'd3);
    check("t2_head",  rx_data,    8'h92);
    rx_ready = 1'b1;
    tick(6);
    rx_ready = 1'b0;
    tick(2);
    check("t2_npop",  popped.size(), 3);
    check("t2_pop0",  popped[0],     8'h92);
    check("t2_pop1",  popped[1],     8'h3C);
    check("t2_pop2",  popped[2],     8'h64);
    check("t2_empty", fifo_count,    3'd0);
    check("t2_valid", rx_valid,      1'b0);

    // Five frames into a four-deep FIFO
    clear_mon();
    for (int i = 1; i <= 5; i++) send_frame(8'(i));
    tick(10);
    check("t3_count", fifo_count, 3'd4);
    check("t3_ovr",   ov_cnt,     1);
    check("t3_head",  rx_data,    8'h01);
    rx_ready = 1'b1;
    tick(8);
    rx_ready = 1'b0;
    check("t3_npop",  popped.size(), 4);
    check("t3_pop0",  popped[0],     8'h01);
    check("t3_pop1",  popped[1],     8'h02);
    check("t3_pop2",  popped[2],     8'h03);
    check("t3_pop3",  popped[3],     8'h04);
    check("t3_empty", fifo_count,    3'd0);

    // Four-cycle low glitch rejected in START
    clear_mon();
    Rx = 1'b0;
    tick(4);
    Rx = 1'b1;
    tick(2);
    check("t4_busy_mid", busy, 1'b1);
    tick(20);
    check("t4_busy_end", busy,       1'b0);
    check("t4_count",    fifo_count, 3'd0);
    check("t4_ferr",     fe_cnt,     0);

    // Stop bit held low for 40 bit times: one frame error, then BREAK
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'(8'h55 >> i));
    Rx = 1'b0;
    tick(40 * CPB);
    check("t5_ferr",      fe_cnt,     1);
    check("t5_busy_brk",  busy,       1'b1);
    check("t5_count",     fifo_count, 3'd0);
    Rx = 1'b1;
    tick(8);
    check("t5_busy_idle", busy, 1'b0);
    rx_ready = 1'b1;
    send_frame(8'hA5);
    tick(10);
    check("t5_npop", popped.size(), 1);
    check("t5_data", popped[0],     8'hA5);
    check("t5_ferr_after", fe_cnt,  1);

    // Reset asserted during DATA of 0xFF
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    Rst_n = 1'b0;
    tick(3);
    Rst_n = 1'b1;
    tick(1);
    check("t6_busy",  busy,       1'b0);
    check("t6_valid", rx_valid,   1'b0);
    check("t6_count", fifo_count, 3'd0);
    check("t6_data",  rx_data,    8'h00);
    check("t6_ferr",  frame_err,  1'b0);
    tick(6 * CPB);
    check("t6_nowr",  popped.size(), 0);
    send_frame(8'h12);
    tick(10);
    check("t6_npop", popped.size(), 1);
    check("t6_next", popped[0],     8'h12);

`ifdef MIDI_RX_MAJORITY_EN
    // One-cycle high glitch at the nominal bit-3 sample point of 0x00
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    Rx = 1'b0;
    tick(8);
    Rx = 1'b1;
    tick(1);
    Rx = 1'b0;
    tick(CPB - 9);
    for (int i = 4; i < 8; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    tick(10);
    check("t7_npop", popped.size(), 1);
    check("t7_data", popped[0],     8'h00);
    check("t7_ferr", fe_cnt,        0);
`endif

    rx_ready = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/midi_rx_fifo.md
Name: midi_rx_fifo

Overview:
- Parametrised MIDI/UART serial receiver, successor to the single-byte MIDI receiver.
- Provides:
  - configurable bit timing and data width
  - input synchroniser
  - mid-bit sampling with false-start rejection
  - stop-bit framing check
  - small output FIFO with valid/ready handshake
- Sits between the MIDI opto-isolator input pin and the MIDI message parser. Bursts such as status + 2 data bytes can arrive while the parser is busy without loss.

Parameters:
- CLKS_PER_BIT, 1600, Clk cycles per serial bit (31250 baud at 50 MHz); must be >= 8.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- Clk, input, 1, system clock.
- Rst_n, input, 1, synchronous active-low reset.
- Rx, input, 1, asynchronous serial line, idle high.
- rx_data, output, DATA_BITS, FIFO head word; valid only while rx_valid=1.
- rx_valid, output, 1, FIFO non-empty.
- rx_ready, input, 1, consumer accepts head when rx_valid && rx_ready at posedge Clk.
- frame_err, output, 1, one-cycle pulse: stop bit sampled low.
- overrun, output, 1, one-cycle pulse: good frame received while FIFO full.
- busy, output, 1, high whenever FSM is not IDLE.
- fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Behaviour:
- Clock and reset: Clk, with reset Rst_n, synchronous, active-low. All state changes on posedge Clk.
- Reset values:
  - FSM=IDLE; synchroniser flops=1; bit counter and clock counter=0.
  - FIFO empty: rx_valid=0, fifo_count=0, rx_data=0.
  - frame_err=0, overrun=0, busy=0.
- Reset mid-frame: partial frame discarded; no FIFO write.
- Synchroniser: Rx passes through 2 flops; rx_s is the second flop. All decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on rx_s==0 -> START, clock counter cleared.
  - START: count to CLKS_PER_BIT/2-1 (integer division), then sample rx_s.
    - 0: -> DATA, counter cleared.
    - 1: glitch, -> IDLE, no flags.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register, LSB first. After DATA_BITS samples -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1: frame good; write shift register to FIFO, -> IDLE.
    - 0: pulse frame_err for 1 cycle, discard word, -> BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. Prevents a held-low break from being read as back-to-back 0x00 frames.
- Latency: FIFO write happens on the cycle after the stop-bit sample. With an empty FIFO, rx_valid rises one cycle after the stop sample, and rx_data presents the word in that same cycle.
- FIFO:
  - Circular buffer with read/write pointers; fifo_count is exact.
  - Pop on rx_valid && rx_ready. rx_data shows the new head on the next cycle, or rx_valid drops if the FIFO is now empty.
  - Simultaneous push and pop when full: pop first; push accepted, no overrun, count unchanged.
  - Simultaneous push and pop when empty: push lands; rx_valid=1 next cycle; count=1.
  - Push when full with no pop: new word dropped, overrun pulses 1 cycle, FIFO contents untouched.
- rx_ready is ignored while rx_valid=0.
- Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro MIDI_RX_MAJORITY_EN.
- Defined: each START/DATA/STOP sample is the 2-of-3 majority of rx_s at the nominal sample cycle -1, 0 and +1. The decision is made at +1, so all sample points and the FIFO write shift one cycle later. This rejects single-cycle glitches on the line.
- Undefined: single sample of rx_s at the nominal cycle; no extra latency.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4):
- Single frame 0x90, rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0x90; frame_err=0, overrun=0, busy falls after STOP.
- Three back-to-back frames 0x92,0x3C,0x64 with rx_ready=0 -> fifo_count=3; then raise rx_ready -> pops in order 0x92,0x3C,0x64; fifo_count ends at 0.
- Five frames with rx_ready=0 -> first four stored; overrun pulses once on the fifth; FIFO head still 0x01-first order, with no corruption of stored words.
- Rx low for 4 cycles only -> START rejects it; no FIFO write, no frame_err; busy returns low.
- Frame 0x55 with stop bit held low for 40 bit times -> one frame_err pulse; FSM stays in BREAK until Rx high; next frame 0xA5 received correctly.
- Rst_n asserted during DATA of frame 0xFF -> no FIFO write, all outputs at reset values; next frame 0x12 received correctly.
- With MIDI_RX_MAJORITY_EN: a 1-cycle high glitch at a data-bit sample point of frame 0x00 -> rx_data=0x00.
